// File: rtl/adc_seq_pkg.sv
// Shared definitions for the flash ADC sequencer.
//   - seq_state_e    : sequencer FSM states
//   - ADC_RES_W      : resolution of the flash encoder output (B/BN)
//   - MISMATCH_CNT_W : width of the saturating B/BN disagreement counter
package adc_seq_pkg;

    localparam int ADC_RES_W      = 3;
    localparam int MISMATCH_CNT_W = 8;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SAMPLE  = 3'd1,
        CONVERT = 3'd2,
        ACCUM   = 3'd3,
        OUT     = 3'd4
    } seq_state_e;

endpackage

// File: rtl/adc_seq_accum.sv
// Datapath of the flash ADC sequencer: captures B/BN, accumulates
// 2^AVG_LOG2 samples and keeps a saturating B/BN disagreement count.
//
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset
//   capture       : latch b_i/bn_i this cycle (eoc seen in CONVERT)
//   accum         : FSM is in ACCUM; add the captured sample
//   clear         : drop the partial/complete accumulation
//   err_clr       : synchronous clear of mismatch_cnt (wins over increment)
//   b_i, bn_i     : flash encoder outputs
//   acc_sum       : accumulator plus the captured sample
//   result_done   : this ACCUM cycle adds the last sample of a result
//   mismatch_cnt  : saturating count of captures with b_i != bn_i
//
// Build option ADC_SEQ_MISMATCH_DROP_EN: a mismatched sample is neither
// accumulated nor counted towards the result, forcing a re-conversion.
module adc_seq_accum
    import adc_seq_pkg::*;
#(
    parameter int AVG_LOG2 = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          capture,
    input  logic                          accum,
    input  logic                          clear,
    input  logic                          err_clr,
    input  logic [ADC_RES_W-1:0]          b_i,
    input  logic [ADC_RES_W-1:0]          bn_i,
    output logic [ADC_RES_W+AVG_LOG2-1:0] acc_sum,
    output logic                          result_done,
    output logic [MISMATCH_CNT_W-1:0]     mismatch_cnt
);

    localparam int ACC_W = ADC_RES_W + AVG_LOG2;
    localparam int CNT_W = AVG_LOG2 + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'((1 << AVG_LOG2) - 1);

    logic [ACC_W-1:0]          acc_q, acc_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [ADC_RES_W-1:0]      b_cap_q, b_cap_d;
    logic [MISMATCH_CNT_W-1:0] mm_cnt_q, mm_cnt_d;
    logic                      mismatch_now;
    logic                      accept;

    assign mismatch_now = (b_i != bn_i);
    assign acc_sum      = acc_q + ACC_W'(b_cap_q);

`ifdef ADC_SEQ_MISMATCH_DROP_EN
    // Remember whether the captured sample disagreed so ACCUM can reject it.
    logic mm_flag_q, mm_flag_d;

    assign mm_flag_d = capture ? mismatch_now : mm_flag_q;
    assign accept    = accum && !mm_flag_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mm_flag_q <= 1'b0;
        end else begin
            mm_flag_q <= mm_flag_d;
        end
    end
`else
    assign accept = accum;
`endif

    // The counter value before the add tells whether this sample completes
    // the result, so the FSM can leave ACCUM in the same cycle.
    assign result_done = accept && (cnt_q == LAST_CNT);

    always_comb begin
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        b_cap_d  = b_cap_q;
        mm_cnt_d = mm_cnt_q;

        if (capture) begin
            b_cap_d = b_i;
        end

        if (clear) begin
            acc_d = '0;
            cnt_d = '0;
        end else if (accept) begin
            acc_d = acc_sum;
            cnt_d = cnt_q + CNT_W'(1);
        end

        // err_clr takes priority over a same-cycle increment.
        if (err_clr) begin
            mm_cnt_d = '0;
        end else if (capture && mismatch_now &&
                     (mm_cnt_q != {MISMATCH_CNT_W{1'b1}})) begin
            mm_cnt_d = mm_cnt_q + MISMATCH_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q    <= '0;
            cnt_q    <= '0;
            b_cap_q  <= '0;
            mm_cnt_q <= '0;
        end else begin
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            b_cap_q  <= b_cap_d;
            mm_cnt_q <= mm_cnt_d;
        end
    end

    assign mismatch_cnt = mm_cnt_q;

endmodule

// File: rtl/adc_flash_sequencer.sv
// Flash ADC sequencer: drives Samp, waits for eoc, captures B/BN, averages
// 2^AVG_LOG2 conversions and hands the sum out on a valid/ready interface.
//
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   en             : continuous conversion enable
//   samp_o         : Samp to the flash logic (high = sample/clear)
//   eoc_i          : end of conversion from the flash logic
//   b_i, bn_i      : flash encoder outputs B[2:0] / BN[2:0]
//   dout           : accumulated sum, low AVG_LOG2 bits are fraction
//   dout_valid     : result available, held until dout_ready
//   dout_ready     : consumer accepts the result
//   mismatch_cnt   : saturating count of captures with b_i != bn_i
//   timeout_err    : sticky, eoc not seen within TIMEOUT cycles
//   err_clr        : synchronous clear of mismatch_cnt and timeout_err
//
// Build option ADC_SEQ_MISMATCH_DROP_EN: mismatched samples are discarded
// and re-converted instead of being accumulated.
module adc_flash_sequencer
    import adc_seq_pkg::*;
#(
    parameter int SAMP_CYCLES = 2,
    parameter int AVG_LOG2    = 2,
    parameter int TIMEOUT     = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          en,
    output logic                          samp_o,
    input  logic                          eoc_i,
    input  logic [ADC_RES_W-1:0]          b_i,
    input  logic [ADC_RES_W-1:0]          bn_i,
    output logic [ADC_RES_W+AVG_LOG2-1:0] dout,
    output logic                          dout_valid,
    input  logic                          dout_ready,
    output logic [MISMATCH_CNT_W-1:0]     mismatch_cnt,
    output logic                          timeout_err,
    input  logic                          err_clr
);

    localparam int ACC_W  = ADC_RES_W + AVG_LOG2;
    localparam int WAIT_W = 8;

    seq_state_e        state_q, state_d;
    logic [3:0]        samp_cnt_q, samp_cnt_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              samp_q, samp_d;
    logic [ACC_W-1:0]  dout_q, dout_d;
    logic              dout_valid_q, dout_valid_d;
    logic              timeout_err_q, timeout_err_d;

    logic              capture;
    logic              accum;
    logic              clear;
    logic [ACC_W-1:0]  acc_sum;
    logic              result_done;

    adc_seq_accum #(
        .AVG_LOG2 (AVG_LOG2)
    ) u_accum (
        .clk          (clk),
        .rst_n        (rst_n),
        .capture      (capture),
        .accum        (accum),
        .clear        (clear),
        .err_clr      (err_clr),
        .b_i          (b_i),
        .bn_i         (bn_i),
        .acc_sum      (acc_sum),
        .result_done  (result_done),
        .mismatch_cnt (mismatch_cnt)
    );

    // Next-state and datapath control. The flash logic raises eoc one edge
    // after Samp falls, so the nominal CONVERT stay is a single cycle.
    always_comb begin
        state_d       = state_q;
        samp_cnt_d    = '0;
        wait_d        = '0;
        dout_d        = dout_q;
        dout_valid_d  = dout_valid_q;
        timeout_err_d = err_clr ? 1'b0 : timeout_err_q;
        capture       = 1'b0;
        accum         = 1'b0;
        clear         = 1'b0;

        case (state_q)
            IDLE: begin
                if (en) begin
                    state_d = SAMPLE;
                end
            end
            SAMPLE: begin
                if (samp_cnt_q == 4'(SAMP_CYCLES - 1)) begin
                    state_d = CONVERT;
                end else begin
                    samp_cnt_d = samp_cnt_q + 4'd1;
                end
            end
            CONVERT: begin
                if (eoc_i) begin
                    capture = 1'b1;
                    state_d = ACCUM;
                end else if (wait_q == WAIT_W'(TIMEOUT)) begin
                    // A timeout set in the same cycle as err_clr stays set.
                    timeout_err_d = 1'b1;
                    clear         = 1'b1;
                    state_d       = IDLE;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            ACCUM: begin
                accum = 1'b1;
                if (result_done) begin
                    dout_d       = acc_sum;
                    dout_valid_d = 1'b1;
                    state_d      = OUT;
                end else begin
                    state_d = SAMPLE;
                end
            end
            OUT: begin
                // Back-pressure holds the ADC in sample until the transfer.
                if (dout_valid_q && dout_ready) begin
                    dout_valid_d = 1'b0;
                    clear        = 1'b1;
                    state_d      = en ? SAMPLE : IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Samp is registered from the next state so it never glitches.
        samp_d = (state_d == IDLE) || (state_d == SAMPLE) || (state_d == OUT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            samp_cnt_q    <= '0;
            wait_q        <= '0;
            samp_q        <= 1'b1;
            dout_q        <= '0;
            dout_valid_q  <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            samp_cnt_q    <= samp_cnt_d;
            wait_q        <= wait_d;
            samp_q        <= samp_d;
            dout_q        <= dout_d;
            dout_valid_q  <= dout_valid_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign samp_o      = samp_q;
    assign dout        = dout_q;
    assign dout_valid  = dout_valid_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_adc_flash_sequencer.sv
// Directed bench for adc_flash_sequencer: a table of B/BN vectors with
// hand-computed results, plus hand-written sequences for back-pressure,
// eoc timeout, mismatch saturation, asynchronous reset and AVG_LOG2=0.
module tb_adc_flash_sequencer;

    localparam int SAMP_CYCLES = 2;
    localparam int AVG_LOG2    = 2;
    localparam int TIMEOUT     = 8;
    localparam int DOUT_W      = 3 + AVG_LOG2;

    typedef struct {
        logic [2:0] b;
        logic [2:0] bn;
        int         exp_dout;
        int         exp_mm;
    } vec_t;

`ifdef ADC_SEQ_MISMATCH_DROP_EN
    localparam int NVEC = 4;
`else
    localparam int NVEC = 5;
`endif

    vec_t vecs [NVEC];
    int   compared   = 0;
    int   mismatched = 0;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              en;
    logic              samp_o;
    logic              eoc_i;
    logic              eoc_en;
    logic [2:0]        b_i;
    logic [2:0]        bn_i;
    logic [DOUT_W-1:0] dout;
    logic              dout_valid;
    logic              dout_ready;
    logic [7:0]        mismatch_cnt;
    logic              timeout_err;
    logic              err_clr;

    // Second instance with AVG_LOG2=0 (one conversion per result).
    logic              en1;
    logic              samp1;
    logic              eoc1;
    logic [2:0]        b1;
    logic [2:0]        dout1;
    logic              valid1;
    logic              ready1;
    logic [7:0]        mm1;
    logic              terr1;
    logic              errclr1;

    always #5 clk = ~clk;

    // Flash logic model: eoc follows one edge after Samp falls.
    assign eoc_i = eoc_en & ~samp_o;
    assign eoc1  = ~samp1;

    adc_flash_sequencer #(
        .SAMP_CYCLES (SAMP_CYCLES),
        .AVG_LOG2    (AVG_LOG2),
        .TIMEOUT     (TIMEOUT)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (en),
        .samp_o       (samp_o),
        .eoc_i        (eoc_i),
        .b_i          (b_i),
        .bn_i         (bn_i),
        .dout         (dout),
        .dout_valid   (dout_valid),
        .dout_ready   (dout_ready),
        .mismatch_cnt (mismatch_cnt),
        .timeout_err  (timeout_err),
        .err_clr      (err_clr)
    );

    adc_flash_sequencer #(
        .SAMP_CYCLES (2),
        .AVG_LOG2    (0),
        .TIMEOUT     (8)
    ) dut_avg0 (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (en1),
        .samp_o       (samp1),
        .eoc_i        (eoc1),
        .b_i          (b1),
        .bn_i         (b1),
        .dout         (dout1),
        .dout_valid   (valid1),
        .dout_ready   (ready1),
        .mismatch_cnt (mm1),
        .timeout_err  (terr1),
        .err_clr      (errclr1)
    );

    task automatic applyStimulus(input logic [2:0] b, input logic [2:0] bn);
        b_i  = b;
        bn_i = bn;
    endtask

    task automatic checkOutput(input string name, input int actual, input int expected);
        compared++;
        if (actual != expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic waitValid(input int limit, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!dout_valid && n < limit);
    endtask

    task automatic waitSamp(input logic level, input string name);
        int n;
        n = 0;
        while (samp_o !== level && n < 50) begin
            tick();
            n++;
        end
        checkOutput(name, int'(samp_o), int'(level));
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int n;
        int valid_seen;

        vecs[0] = '{b: 3'd5, bn: 3'd5, exp_dout: 20, exp_mm: 0};
        vecs[1] = '{b: 3'd7, bn: 3'd7, exp_dout: 28, exp_mm: 0};
        vecs[2] = '{b: 3'd0, bn: 3'd0, exp_dout: 0,  exp_mm: 0};
`ifdef ADC_SEQ_MISMATCH_DROP_EN
        vecs[3] = '{b: 3'd2, bn: 3'd2, exp_dout: 8,  exp_mm: 0};
`else
        vecs[3] = '{b: 3'd3, bn: 3'd4, exp_dout: 12, exp_mm: 4};
        vecs[4] = '{b: 3'd6, bn: 3'd2, exp_dout: 24, exp_mm: 8};
`endif

        rst_n      = 1'b0;
        en         = 1'b1;
        eoc_en     = 1'b1;
        dout_ready = 1'b1;
        err_clr    = 1'b0;
        en1        = 1'b0;
        b1         = 3'd7;
        ready1     = 1'b1;
        errclr1    = 1'b0;
        applyStimulus(3'd0, 3'd0);

        // Reset values.
        tick();
        tick();
        checkOutput("reset_samp_o", int'(samp_o), 1);
        checkOutput("reset_dout_valid", int'(dout_valid), 0);
        checkOutput("reset_dout", int'(dout), 0);
        checkOutput("reset_mm_cnt", int'(mismatch_cnt), 0);
        checkOutput("reset_timeout_err", int'(timeout_err), 0);

        // Table: one result per vector, 17 cycles apart with ready=1.
        for (int i = 0; i < NVEC; i++) begin
            applyStimulus(vecs[i].b, vecs[i].bn);
            if (i == 0) begin
                @(negedge clk);
                rst_n = 1'b1;
            end
            waitValid(40, n);
            checkOutput($sformatf("vec%0d_latency", i), n, 17);
            checkOutput($sformatf("vec%0d_dout", i), int'(dout), vecs[i].exp_dout);
            checkOutput($sformatf("vec%0d_mm_cnt", i), int'(mismatch_cnt), vecs[i].exp_mm);
        end

        // Back-pressure: the last result is held, ADC stays in sample.
        dout_ready = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            checkOutput($sformatf("stall%0d_dout", k), int'(dout), vecs[NVEC-1].exp_dout);
            checkOutput($sformatf("stall%0d_valid", k), int'(dout_valid), 1);
            checkOutput($sformatf("stall%0d_samp", k), int'(samp_o), 1);
        end
        dout_ready = 1'b1;
        tick();
        checkOutput("release_valid", int'(dout_valid), 0);
        checkOutput("release_samp_c1", int'(samp_o), 1);
        tick();
        checkOutput("release_samp_c2", int'(samp_o), 1);
        tick();
        checkOutput("release_samp_convert", int'(samp_o), 0);

        // eoc timeout after two good conversions of a result.
        applyStimulus(3'd7, 3'd7);
        waitSamp(1'b1, "to_conv2_sample");
        waitSamp(1'b0, "to_conv2_convert");
        waitSamp(1'b1, "to_conv3_sample");
        eoc_en = 1'b0;
        en     = 1'b0;
        waitSamp(1'b0, "to_conv3_convert");
        n = 0;
        do begin
            tick();
            n++;
        end while (!timeout_err && n < 30);
        checkOutput("timeout_latency", n, 9);
        checkOutput("timeout_samp_idle", int'(samp_o), 1);
        checkOutput("timeout_valid", int'(dout_valid), 0);
        repeat (3) tick();
        checkOutput("timeout_stays_idle", int'(samp_o), 1);
        checkOutput("timeout_sticky", int'(timeout_err), 1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        checkOutput("timeout_cleared", int'(timeout_err), 0);

        // Partial accumulation was discarded: a fresh result of 4 x 1.
        eoc_en = 1'b1;
        en     = 1'b1;
        applyStimulus(3'd1, 3'd1);
        waitValid(40, n);
        checkOutput("post_timeout_latency", n, 17);
        checkOutput("post_timeout_dout", int'(dout), 4);

        // Persistent B/BN disagreement.
        applyStimulus(3'd3, 3'd4);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        checkOutput("mm_cleared", int'(mismatch_cnt), 0);
`ifndef ADC_SEQ_MISMATCH_DROP_EN
        waitValid(40, n);
        checkOutput("mm_result_dout", int'(dout), 12);
        checkOutput("mm_result_cnt", int'(mismatch_cnt), 4);
`endif
        n          = 0;
        valid_seen = 0;
        while (mismatch_cnt != 8'd255 && n < 3000) begin
            tick();
            n++;
            if (dout_valid) valid_seen = 1;
        end
        checkOutput("mm_reach_255", int'(mismatch_cnt), 255);
`ifdef ADC_SEQ_MISMATCH_DROP_EN
        checkOutput("drop_no_valid", valid_seen, 0);
`endif
        repeat (40) tick();
        checkOutput("mm_saturated", int'(mismatch_cnt), 255);

        // Asynchronous reset during CONVERT, checked before the next edge.
        waitSamp(1'b1, "rst_seek_sample");
        waitSamp(1'b0, "rst_seek_convert");
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_rst_samp", int'(samp_o), 1);
        checkOutput("async_rst_valid", int'(dout_valid), 0);
        checkOutput("async_rst_mm_cnt", int'(mismatch_cnt), 0);
        checkOutput("async_rst_dout", int'(dout), 0);
        en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // AVG_LOG2=0: one result every SAMP_CYCLES+3 cycles.
        tick();
        en1 = 1'b1;
        for (int r = 0; r < 3; r++) begin
            n = 0;
            do begin
                tick();
                n++;
            end while (!valid1 && n < 20);
            checkOutput($sformatf("avg0_r%0d_period", r), n, 5);
            checkOutput($sformatf("avg0_r%0d_dout", r), int'(dout1), 7);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
